choice_1of5_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises one 1-of-5 choice implementation (any architecture selected in the choice hub) with all 32 input vectors.
- Compares the implementation's output against a built-in golden model and reports error statistics.
- Sits between a start/done control source (board buttons/LEDs or testbench) and the hub instance; drives the hub's x, samples its y.
- Golden function: y = 1 iff exactly one bit of x is 1.

---
 rtl/choice_1of5_sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_choice_1of5_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/choice_1of5_sweep_ctrl.sv
// Sweep sequencer for a 1-of-5 choice implementation: drives all 32 vectors, checks y against
// the one-hot golden function and keeps error statistics. CHOICE_SWEEP_TRUTH_EN adds a captured truth table.
module choice_1of5_sweep_ctrl #(
    parameter int unsigned SETTLE    = 2,
    parameter logic [4:0]  START_VEC = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  x_out,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic [5:0]  err_cnt,
    output logic [5:0]  ones_cnt,
    output logic [4:0]  first_err,
`ifdef CHOICE_SWEEP_TRUTH_EN
    output logic [31:0] truth_tbl,
`endif
    output logic        err_flag
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [4:0] LAST_VEC    = START_VEC - 5'd1;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("choice_1of5_sweep_ctrl: SETTLE must be within 1..15");
        end
    endgenerate

    logic [1:0] state_reg, state_next;
    logic [4:0] x_reg, x_next;
    logic [3:0] settle_reg, settle_next;
    logic [5:0] err_reg, err_next;
    logic [5:0] ones_reg, ones_next;
    logic [4:0] first_reg, first_next;
    logic       flag_reg, flag_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    // Golden model as a ripple of "seen a one" / "seen two ones" flags across x.
    logic [5:0] seen_chain;
    logic [5:0] multi_chain;
    logic       golden_y;

    assign seen_chain[0]  = 1'b0;
    assign multi_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_onehot
            assign seen_chain[gi+1]  = seen_chain[gi] | x_reg[gi];
            assign multi_chain[gi+1] = multi_chain[gi] | (seen_chain[gi] & x_reg[gi]);
        end
    endgenerate

    assign golden_y = seen_chain[5] & ~multi_chain[5];

    logic start_accept;
    logic sample_cycle;
    logic mismatch;

    assign start_accept = (state_reg == ST_IDLE) && start;
    assign sample_cycle = (state_reg == ST_SAMPLE);
    assign mismatch     = golden_y != y_in;

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        settle_next = settle_reg;
        err_next    = err_reg;
        ones_next   = ones_reg;
        first_next  = first_reg;
        flag_next   = flag_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_DRIVE;
                    x_next      = START_VEC;
                    settle_next = SETTLE_LOAD;
                    err_next    = 6'd0;
                    ones_next   = 6'd0;
                    first_next  = 5'd0;
                    flag_next   = 1'b0;
                    busy_next   = 1'b1;
                end
            end

            ST_DRIVE: begin
                if (settle_reg == 4'd0) begin
                    state_next = ST_SAMPLE;
                end else begin
                    settle_next = settle_reg - 4'd1;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    err_next = err_reg + 6'd1;
                    if (!flag_reg) begin
                        first_next = x_reg;
                        flag_next  = 1'b1;
                    end
                end
                if (y_in) begin
                    ones_next = ones_reg + 6'd1;
                end
                if (x_reg == LAST_VEC) begin
                    state_next = ST_DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    x_next      = x_reg + 5'd1;
                    settle_next = SETTLE_LOAD;
                    state_next  = ST_DRIVE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            x_reg      <= START_VEC;
            settle_reg <= 4'd0;
            err_reg    <= 6'd0;
            ones_reg   <= 6'd0;
            first_reg  <= 5'd0;
            flag_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            settle_reg <= settle_next;
            err_reg    <= err_next;
            ones_reg   <= ones_next;
            first_reg  <= first_next;
            flag_reg   <= flag_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

`ifdef CHOICE_SWEEP_TRUTH_EN
    // One flop per vector; written only during the SAMPLE of its own vector.
    logic [31:0] truth_reg;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_truth
            always_ff @(posedge clk) begin
                if (rst || start_accept) begin
                    truth_reg[gi] <= 1'b0;
                end else if (sample_cycle && (x_reg == 5'(gi))) begin
                    truth_reg[gi] <= y_in;
                end
            end
        end
    endgenerate

    assign truth_tbl = truth_reg;
`else
    logic unused_truth;
    assign unused_truth = start_accept ^ sample_cycle;
`endif

    assign x_out     = x_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err_cnt   = err_reg;
    assign ones_cnt  = ones_reg;
    assign first_err = first_reg;
    assign err_flag  = flag_reg;

endmodule

// File: tb/tb_choice_1of5_sweep_ctrl.sv
// Directed + randomized bench for choice_1of5_sweep_ctrl; two instances (SETTLE=2/START_VEC=0 and
// SETTLE=3/START_VEC=4) each drive a table-based fake hub checked against a sweep-level reference model.
module tb_choice_1of5_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a   [2];
    logic [31:0] impl_a    [2];
    logic [4:0]  x_a       [2];
    logic        y_a       [2];
    logic        busy_a    [2];
    logic        done_a    [2];
    logic [5:0]  err_a     [2];
    logic [5:0]  ones_a    [2];
    logic [4:0]  first_a   [2];
    logic        flag_a    [2];
`ifdef CHOICE_SWEEP_TRUTH_EN
    logic [31:0] truth_a   [2];
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign y_a[0] = impl_a[0][x_a[0]];
    assign y_a[1] = impl_a[1][x_a[1]];

    choice_1of5_sweep_ctrl #(.SETTLE(2), .START_VEC(5'd0)) dut0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .x_out(x_a[0]), .y_in(y_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .err_cnt(err_a[0]), .ones_cnt(ones_a[0]),
        .first_err(first_a[0]),
`ifdef CHOICE_SWEEP_TRUTH_EN
        .truth_tbl(truth_a[0]),
`endif
        .err_flag(flag_a[0])
    );

    choice_1of5_sweep_ctrl #(.SETTLE(3), .START_VEC(5'd4)) dut1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .x_out(x_a[1]), .y_in(y_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .err_cnt(err_a[1]), .ones_cnt(ones_a[1]),
        .first_err(first_a[1]),
`ifdef CHOICE_SWEEP_TRUTH_EN
        .truth_tbl(truth_a[1]),
`endif
        .err_flag(flag_a[1])
    );

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int start_of(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the sweep order and score each vector against "exactly one bit set".
    task automatic model(input int d, input logic [31:0] tbl, output int e_err, output int e_ones,
                         output int e_first, output bit e_flag);
        e_err = 0; e_ones = 0; e_first = 0; e_flag = 0;
        for (int i = 0; i < 32; i++) begin
            int v;
            bit gold;
            v = (start_of(d) + i) % 32;
            gold = ($countones(v) == 1);
            if (tbl[v]) e_ones++;
            if (tbl[v] != gold) begin
                e_err++;
                if (!e_flag) begin
                    e_first = v;
                    e_flag  = 1;
                end
            end
        end
    endtask

    task automatic wait_done(input int d, output int cyc, output bit ok);
        cyc = 0;
        ok  = 0;
        while (cyc < 1000 && !ok) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_a[d]) ok = 1;
        end
    endtask

    task automatic accept(input int d);
        @(posedge clk);
        #1 start_a[d] = 1'b1;
        @(posedge clk);
        #1 start_a[d] = 1'b0;
    endtask

    task automatic check_results(input int d, input logic [31:0] tbl, input string tag);
        int  e_err, e_ones, e_first;
        bit  e_flag;
        model(d, tbl, e_err, e_ones, e_first, e_flag);
        check({tag, ".err_cnt"},   32'(err_a[d]),   32'(e_err));
        check({tag, ".ones_cnt"},  32'(ones_a[d]),  32'(e_ones));
        check({tag, ".err_flag"},  32'(flag_a[d]),  32'(e_flag));
        if (e_flag) check({tag, ".first_err"}, 32'(first_a[d]), 32'(e_first));
`ifdef CHOICE_SWEEP_TRUTH_EN
        check({tag, ".truth_tbl"}, truth_a[d], tbl);
`endif
    endtask

    task automatic run_sweep(input int d, input logic [31:0] tbl, input string tag);
        int cyc;
        bit ok;
        impl_a[d] = tbl;
        accept(d);
        check({tag, ".busy_after_start"}, 32'(busy_a[d]), 32'd1);
        wait_done(d, cyc, ok);
        check({tag, ".done_seen"}, 32'(ok), 32'd1);
        // done is first high in the cycle ending at edge cyc+1 after acceptance
        check({tag, ".latency"}, 32'(cyc + 1), 32'(32 * (settle_of(d) + 1) + 1));
        check({tag, ".busy_in_done"}, 32'(busy_a[d]), 32'd0);
        check({tag, ".x_last"}, 32'(x_a[d]), 32'((start_of(d) + 31) % 32));
        check_results(d, tbl, tag);
        @(posedge clk);
        #1;
        check({tag, ".done_one_cycle"}, 32'(done_a[d]), 32'd0);
        $display("sweep %s dut%0d tbl=0x%08h err=%0d ones=%0d first=%0d flag=%0d", tag, d, tbl,
                 err_a[d], ones_a[d], first_a[d], flag_a[d]);
    endtask

    localparam logic [31:0] GOLD_TBL = 32'h0001_0116;

    initial begin
        int  cyc, cnt;
        bit  ok;
        rst = 1'b1;
        start_a[0] = 1'b0; start_a[1] = 1'b0;
        impl_a[0] = GOLD_TBL; impl_a[1] = GOLD_TBL;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            check("reset.x_out",     32'(x_a[d]),     32'(start_of(d)));
            check("reset.busy",      32'(busy_a[d]),  32'd0);
            check("reset.done",      32'(done_a[d]),  32'd0);
            check("reset.err_cnt",   32'(err_a[d]),   32'd0);
            check("reset.ones_cnt",  32'(ones_a[d]),  32'd0);
            check("reset.first_err", 32'(first_a[d]), 32'd0);
            check("reset.err_flag",  32'(flag_a[d]),  32'd0);
`ifdef CHOICE_SWEEP_TRUTH_EN
            check("reset.truth_tbl", truth_a[d], 32'd0);
`endif
        end

        run_sweep(0, GOLD_TBL, "golden");
        run_sweep(0, 32'd0, "stuck0");
        run_sweep(1, GOLD_TBL | 32'h8, "extra3_wrap");
        run_sweep(1, GOLD_TBL, "golden_s3");
        for (int r = 0; r < 4; r++) begin
            run_sweep(0, $urandom, "rand0");
            run_sweep(1, $urandom, "rand1");
        end

        // Reset at cycle 40 of a sweep aborts it without a done pulse.
        impl_a[0] = 32'd0;
        accept(0);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort.busy",     32'(busy_a[0]),  32'd0);
        check("abort.x_out",    32'(x_a[0]),     32'd0);
        check("abort.err_cnt",  32'(err_a[0]),   32'd0);
        check("abort.ones_cnt", 32'(ones_a[0]),  32'd0);
        check("abort.err_flag", 32'(flag_a[0]),  32'd0);
        cnt = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (done_a[0]) cnt++;
        end
        check("abort.no_done", 32'(cnt), 32'd0);
        $display("abort test: done pulses after reset=%0d", cnt);

        // start held high: back-to-back sweeps, counts cleared in between.
        impl_a[0] = 32'd0;
        @(posedge clk);
        #1 start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, cyc, ok);
        check("hold.first_done", 32'(ok), 32'd1);
        check("hold.first_err_cnt", 32'(err_a[0]), 32'd5);
        @(posedge clk);
        #1 check("hold.idle_busy", 32'(busy_a[0]), 32'd0);
        @(posedge clk);
        #1;
        check("hold.cleared_err", 32'(err_a[0]), 32'd0);
        check("hold.cleared_flag", 32'(flag_a[0]), 32'd0);
        check("hold.busy_again", 32'(busy_a[0]), 32'd1);
        wait_done(0, cyc, ok);
        start_a[0] = 1'b0;
        check("hold.second_done", 32'(ok), 32'd1);
        check("hold.gap", 32'(cyc + 2), 32'd98);
        check_results(0, 32'd0, "hold");
        $display("hold test: second done %0d cycles after first", cyc + 2);
        repeat (2) @(posedge clk);
        #1;

        // start pulsed while busy is ignored.
        impl_a[0] = GOLD_TBL;
        accept(0);
        repeat (20) @(posedge clk);
        #1 start_a[0] = 1'b1;
        @(posedge clk);
        #1 start_a[0] = 1'b0;
        wait_done(0, cyc, ok);
        check("busy_start.done", 32'(ok), 32'd1);
        check("busy_start.latency", 32'(21 + cyc + 1), 32'd97);
        check_results(0, GOLD_TBL, "busy_start");
        cnt = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (done_a[0]) cnt++;
        end
        check("busy_start.single_done", 32'(cnt), 32'd0);
        $display("busy-start test: latency=%0d extra done pulses=%0d", 21 + cyc + 1, cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
